fcp_tx_frame_gen: RTL and testbench
===================================

Name: fcp_tx_frame_gen

Overview:
Parametrised successor to the FCP single-wire transmitter. It serialises either a slave ping or a multi-byte data frame onto the one-bit FCP line.
- Data frame: 1..MAX_BYTES payload bytes, each preceded by a sync field and followed by odd parity, plus an optional CRC-8 byte computed on the fly and a closing ping.
- UI length is a runtime input, so the analog/trim logic can retune without rebuilding.
- Sits between the FCP protocol controller and the line driver.

Parameters:
- UI_W, 8: width of ui_cycle input (clocks per UI).
- MAX_BYTES, 4: maximum payload bytes per frame.
- LEN_W, 3: width of tx_len; must hold MAX_BYTES.
- PING_UI, 16: ping duration in UI.
- CRC_POLY, 8'h07: CRC-8 polynomial (init 8'h00, MSB-first, no reflection, no final XOR).

Ports:
- clk  in  1  system clock.
- rstn  in  1  asynchronous active-low reset.
- start  in  1  one-cycle request, sampled when idle.
- tx_type  in  1  0 = ping only, 1 = data frame.
- tx_len  in  LEN_W  payload byte count.
- tx_data  in  8*MAX_BYTES  payload; byte0 = [7:0], sent first.
- crc_append  in  1  1 = send CRC byte after payload.
- ui_cycle  in  UI_W  clocks per UI (U).
- abort  in  1  synchronous cancel.
- data  out  1  FCP line, registered.
- busy  out  1  frame in progress.
- done  out  1  one-cycle pulse, frame completed normally.
- err  out  1  one-cycle pulse, start rejected.
- aborted  out  1  one-cycle pulse, frame cancelled.

Behaviour:
- One clock; reset is asynchronous and active-low (clk, rstn).
- Reset values: data=0, busy=0, done=0, err=0, aborted=0; FSM in IDLE; all counters 0.
- Launch qualification, at cycle T with start=1 in IDLE:
  - Reject if ui_cycle<8, or if tx_type=1 and (tx_len==0 or tx_len>MAX_BYTES).
  - Reject → err=1 at T+1; state stays IDLE; data unchanged.
  - Accept → at T+1: busy=1 and data shows the first segment's level. tx_type, tx_len, tx_data, crc_append and ui_cycle are captured; later changes to these inputs are ignored.
- Timing: U = captured ui_cycle; Q = U>>2 (floor; U=22 gives Q=5).
- start while busy: ignored, no err.
- FSM states: IDLE, SYNC, BIT, PAR, PING.
  - IDLE→PING on accepted start with tx_type=0.
  - IDLE→SYNC on accepted start with tx_type=1.
  - SYNC: 4 segments of Q cycles; data = 1,0,1,0. Then → BIT.
  - BIT: 8 bits of U cycles each, MSB first; data = bit. Then → PAR.
  - PAR: U cycles; data = ~^byte (odd parity over byte+parity).
    - More bytes remain → SYNC.
    - Else → PING.
  - PING: data=1 for PING_UI*U cycles. Then → IDLE.
  - Byte order: payload byte0..byte(tx_len-1), then the CRC byte if crc_append=1.
  - Data-frame byte count N = tx_len + crc_append.
- Busy duration:
  - Data frame: N*(4Q+9U) + PING_UI*U cycles.
  - Ping only: PING_UI*U cycles.
- Completion: on the cycle after the last PING cycle, data=0, busy=0, done=1 (all together).
- CRC:
  - Cleared to 0 on accept.
  - Advanced once per payload data bit, at the end of that bit's UI.
  - Not advanced over parity bits or over the CRC byte itself.
  - Final value latched as the CRC byte before its SYNC begins.
- abort=1 while busy: next cycle data=0, busy=0, aborted=1; state IDLE; no done. abort in IDLE is ignored.
- abort and start in the same IDLE cycle: start is processed normally; abort is ignored.
- Counters: cycle counter is UI_W+1 bits; byte index wraps only by returning to IDLE; no counter ever exceeds its terminal value.
- Reset mid-frame: immediate return to reset values, no done or aborted pulse.

Test Plan:
- Ping: tx_type=0, ui_cycle=20 → busy high exactly 320 cycles; data=1 for those cycles; done pulses once; data=0 afterwards.
- Single byte, no CRC: tx_type=1, tx_len=1, byte0=8'hA5, U=20 → data = 1,0,1,0 (5 cycles each), then 1,0,1,0,0,1,0,1 (20 each), parity 1, then ping 320 cycles; busy=520 cycles; done once.
- CRC append: byte0=8'h01, crc_append=1, U=20 → second byte on the line is 8'h07 with parity 0; busy = 2*200+320 = 720 cycles.
- Max frame with odd U: tx_len=4, bytes 8'h00/8'hFF/8'h80/8'h7F, U=22 (Q=5) → parities 1,1,0,0; busy = 4*218+352 = 1224 cycles.
- Rejects: ui_cycle=7; tx_len=0; tx_len=5 → each gives err=1 for one cycle, busy stays 0, data unchanged. start during busy → ignored, frame unaffected.
- Abort/reset: abort at cycle 100 of the 8'hA5 frame → data=0, busy=0, aborted=1 next cycle, no done; a fresh start then sends a correct frame. rstn low mid-frame → all outputs 0 immediately.

Source files
------------

// File: rtl/fcp_tx_frame_gen_if.sv
// Request/status bundle between the FCP protocol controller and the
// single-wire frame generator.
//   start/tx_type/tx_len/tx_data/crc_append/ui_cycle/abort : controller -> generator
//   data/busy/done/err/aborted                             : generator -> controller/line
interface fcp_tx_frame_gen_if #(
  parameter int unsigned UI_W      = 8,
  parameter int unsigned MAX_BYTES = 4,
  parameter int unsigned LEN_W     = 3
);
  logic                   start;
  logic                   tx_type;
  logic [LEN_W-1:0]       tx_len;
  logic [8*MAX_BYTES-1:0] tx_data;
  logic                   crc_append;
  logic [UI_W-1:0]        ui_cycle;
  logic                   abort;
  logic                   data;
  logic                   busy;
  logic                   done;
  logic                   err;
  logic                   aborted;

  modport master (
    output start, tx_type, tx_len, tx_data, crc_append, ui_cycle, abort,
    input  data, busy, done, err, aborted
  );

  modport slave (
    input  start, tx_type, tx_len, tx_data, crc_append, ui_cycle, abort,
    output data, busy, done, err, aborted
  );
endinterface

// File: rtl/fcp_tx_frame_gen.sv
// FCP single-wire transmitter: serialises a slave ping or a data frame
// (sync + 8 data bits MSB first + odd parity per byte, optional CRC-8 byte,
// closing ping) onto the registered line output.
// Ports:
//   clk   - system clock
//   rstn  - asynchronous active-low reset
//   bus   - slave side of fcp_tx_frame_gen_if (request fields in,
//           line level and status pulses out)
module fcp_tx_frame_gen #(
  parameter int unsigned UI_W      = 8,
  parameter int unsigned MAX_BYTES = 4,
  parameter int unsigned LEN_W     = 3,
  parameter int unsigned PING_UI   = 16,
  parameter logic [7:0]  CRC_POLY  = 8'h07
) (
  input  logic                 clk,
  input  logic                 rstn,
  fcp_tx_frame_gen_if.slave    bus
);

  localparam int unsigned CNT_W  = UI_W + 1;
  localparam int unsigned SEG_W  = (PING_UI > 8) ? $clog2(PING_UI) : 3;
  localparam int unsigned BYTE_W = LEN_W + 1;

  typedef enum logic [2:0] {IDLE, SYNC, BIT, PAR, PING} state_t;

  state_t                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [SEG_W-1:0]       seg_q, seg_d;
  logic [BYTE_W-1:0]      byte_q, byte_d;
  logic [LEN_W-1:0]       len_q, len_d;
  logic [8*MAX_BYTES-1:0] pay_q, pay_d;
  logic                   crc_app_q, crc_app_d;
  logic [UI_W-1:0]        ui_q, ui_d;
  logic [7:0]             crc_q, crc_d;
  logic                   data_q, data_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic                   err_q, err_d;
  logic                   abt_q, abt_d;

  logic [CNT_W-1:0]  u_len, q_len, seg_len;
  logic              seg_end;
  logic [BYTE_W-1:0] n_bytes;
  logic              last_byte;
  logic              is_payload;
  logic [7:0]        cur_byte;
  logic              cur_bit;
  logic [7:0]        crc_next;
  logic              reject;

  assign u_len      = {1'b0, ui_q};
  assign q_len      = u_len >> 2;
  assign seg_len    = (state_q == SYNC) ? q_len : u_len;
  assign seg_end    = (cnt_q == seg_len - CNT_W'(1));
  assign n_bytes    = BYTE_W'(len_q) + BYTE_W'(crc_app_q);
  assign last_byte  = (byte_q == n_bytes - BYTE_W'(1));
  assign is_payload = (byte_q < BYTE_W'(len_q));

  // Byte on the wire: payload slot while inside tx_len, otherwise the CRC
  // register, which stops advancing once the payload bits are exhausted.
  always_comb begin
    cur_byte = crc_q;
    for (int unsigned i = 0; i < MAX_BYTES; i++) begin
      if (is_payload && (byte_q == BYTE_W'(i))) begin
        cur_byte = pay_q[i*8 +: 8];
      end
    end
  end

  // seg_q counts bits 0..7; bit index 7-k is the bitwise inverse of k.
  assign cur_bit  = cur_byte[~seg_q[2:0]];
  assign crc_next = {crc_q[6:0], 1'b0} ^ ((crc_q[7] ^ cur_bit) ? CRC_POLY : 8'h00);

  assign reject = (bus.ui_cycle < UI_W'(8)) ||
                  (bus.tx_type && ((bus.tx_len == '0) ||
                                   ({1'b0, bus.tx_len} > BYTE_W'(MAX_BYTES))));

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    seg_d     = seg_q;
    byte_d    = byte_q;
    len_d     = len_q;
    pay_d     = pay_q;
    crc_app_d = crc_app_q;
    ui_d      = ui_q;
    crc_d     = crc_q;
    data_d    = data_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    err_d     = 1'b0;
    abt_d     = 1'b0;

    if (state_q == IDLE) begin
      if (bus.start) begin
        if (reject) begin
          err_d = 1'b1;
        end else begin
          len_d     = bus.tx_len;
          pay_d     = bus.tx_data;
          crc_app_d = bus.crc_append;
          ui_d      = bus.ui_cycle;
          crc_d     = '0;
          cnt_d     = '0;
          seg_d     = '0;
          byte_d    = '0;
          busy_d    = 1'b1;
          data_d    = 1'b1;
          state_d   = bus.tx_type ? SYNC : PING;
        end
      end
    end else if (bus.abort) begin
      state_d = IDLE;
      cnt_d   = '0;
      seg_d   = '0;
      byte_d  = '0;
      data_d  = 1'b0;
      busy_d  = 1'b0;
      abt_d   = 1'b1;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
      if (seg_end) begin
        cnt_d = '0;
        // data_d always carries the level of the segment that starts next.
        unique case (state_q)
          SYNC: begin
            if (seg_q == SEG_W'(3)) begin
              state_d = BIT;
              seg_d   = '0;
              data_d  = cur_byte[7];
            end else begin
              seg_d  = seg_q + SEG_W'(1);
              data_d = seg_q[0];
            end
          end
          BIT: begin
            if (is_payload) begin
              crc_d = crc_next;
            end
            if (seg_q == SEG_W'(7)) begin
              state_d = PAR;
              seg_d   = '0;
              data_d  = ~^cur_byte;
            end else begin
              seg_d  = seg_q + SEG_W'(1);
              data_d = cur_byte[~(seg_q[2:0] + 3'd1)];
            end
          end
          PAR: begin
            seg_d  = '0;
            data_d = 1'b1;
            if (last_byte) begin
              state_d = PING;
            end else begin
              state_d = SYNC;
              byte_d  = byte_q + BYTE_W'(1);
            end
          end
          PING: begin
            if (seg_q == SEG_W'(PING_UI - 1)) begin
              state_d = IDLE;
              seg_d   = '0;
              byte_d  = '0;
              data_d  = 1'b0;
              busy_d  = 1'b0;
              done_d  = 1'b1;
            end else begin
              seg_d = seg_q + SEG_W'(1);
            end
          end
          default: begin
            state_d = IDLE;
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      seg_q     <= '0;
      byte_q    <= '0;
      len_q     <= '0;
      pay_q     <= '0;
      crc_app_q <= 1'b0;
      ui_q      <= '0;
      crc_q     <= '0;
      data_q    <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      abt_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      seg_q     <= seg_d;
      byte_q    <= byte_d;
      len_q     <= len_d;
      pay_q     <= pay_d;
      crc_app_q <= crc_app_d;
      ui_q      <= ui_d;
      crc_q     <= crc_d;
      data_q    <= data_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      err_q     <= err_d;
      abt_q     <= abt_d;
    end
  end

  assign bus.data    = data_q;
  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.err     = err_q;
  assign bus.aborted = abt_q;

endmodule

// File: tb/tb_fcp_tx_frame_gen.sv
// Bench for fcp_tx_frame_gen: a cycle-level expectation queue built from
// the frame rules, checked every cycle, plus literal checks on decoded
// line traces for the directed frames.
module tb_fcp_tx_frame_gen;

  logic clk;
  logic rstn;
  int   total = 0;
  int   bad   = 0;

  typedef struct packed {
    logic data;
    logic busy;
    logic done;
    logic err;
    logic ab;
  } exp_t;

  exp_t expq[$];
  logic trace[$];

  fcp_tx_frame_gen_if #(.UI_W(8), .MAX_BYTES(4), .LEN_W(3)) bus ();

  fcp_tx_frame_gen #(
    .UI_W(8), .MAX_BYTES(4), .LEN_W(3), .PING_UI(16), .CRC_POLY(8'h07)
  ) dut (
    .clk (clk),
    .rstn(rstn),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic exp_t mk(logic d, logic b, logic dn, logic er, logic ab);
    exp_t e;
    e.data = d; e.busy = b; e.done = dn; e.err = er; e.ab = ab;
    return e;
  endfunction

  function automatic logic [7:0] crc8(logic [7:0] bl[$], int n);
    logic [7:0] c = 8'h00;
    for (int i = 0; i < n; i++) begin
      for (int k = 7; k >= 0; k--) begin
        if (c[7] ^ bl[i][k]) c = (c << 1) ^ 8'h07;
        else                 c = c << 1;
      end
    end
    return c;
  endfunction

  // Expected output sequence for one request, starting the cycle after start.
  task automatic model_launch(input bit typ, input int len, input logic [31:0] d,
                              input bit ce, input int u);
    logic [7:0] bl[$];
    int q;
    if (u < 8 || (typ && (len == 0 || len > 4))) begin
      expq.push_back(mk(0, 0, 0, 1, 0));
      return;
    end
    q = u / 4;
    if (typ) begin
      for (int i = 0; i < len; i++) bl.push_back(d[i*8 +: 8]);
      if (ce) bl.push_back(crc8(bl, len));
      foreach (bl[b]) begin
        for (int s = 0; s < 4; s++)
          for (int c = 0; c < q; c++) expq.push_back(mk((s % 2) == 0, 1, 0, 0, 0));
        for (int k = 7; k >= 0; k--)
          for (int c = 0; c < u; c++) expq.push_back(mk(bl[b][k], 1, 0, 0, 0));
        for (int c = 0; c < u; c++) expq.push_back(mk(~^bl[b], 1, 0, 0, 0));
      end
    end
    for (int c = 0; c < 16 * u; c++) expq.push_back(mk(1, 1, 0, 0, 0));
    expq.push_back(mk(0, 0, 1, 0, 0));
  endtask

  // Per-cycle compare; idle outputs expected whenever nothing is queued.
  always @(negedge clk) begin
    exp_t e;
    if (rstn) begin
      e = (expq.size() > 0) ? expq.pop_front() : exp_t'('0);
      check("outputs", 32'({bus.data, bus.busy, bus.done, bus.err, bus.aborted}), 32'(e));
      if (bus.busy) trace.push_back(bus.data);
    end
  end

  function automatic logic [7:0] decode(int base, int u);
    logic [7:0] r;
    for (int k = 0; k < 8; k++) r[7-k] = trace[base + u*k + u/2];
    return r;
  endfunction

  task automatic run_frame(input bit typ, input int len, input logic [31:0] d,
                           input bit ce, input int u, input int abort_at,
                           input bit mid_start, input bit start_abort);
    int cyc;
    @(negedge clk); #1;
    trace.delete();
    bus.tx_type    = typ;
    bus.tx_len     = 3'(len);
    bus.tx_data    = d;
    bus.crc_append = ce;
    bus.ui_cycle   = 8'(u);
    bus.start      = 1'b1;
    bus.abort      = start_abort;
    model_launch(typ, len, d, ce, u);
    @(negedge clk); #1;
    bus.start      = 1'b0;
    bus.abort      = 1'b0;
    bus.tx_type    = 1'($urandom);
    bus.tx_len     = 3'($urandom);
    bus.tx_data    = $urandom;
    bus.crc_append = 1'($urandom);
    bus.ui_cycle   = 8'($urandom);
    cyc = 1;
    while (expq.size() > 0 && cyc < 4000) begin
      if (cyc == abort_at && expq.size() >= 2) begin
        expq.delete();
        expq.push_back(mk(0, 0, 0, 0, 1));
        bus.abort = 1'b1;
      end else if (mid_start && cyc == 37 && expq.size() >= 2) begin
        bus.start    = 1'b1;
        bus.tx_type  = 1'($urandom);
        bus.tx_len   = 3'($urandom_range(1, 4));
        bus.ui_cycle = 8'($urandom_range(8, 30));
      end
      @(negedge clk); #1;
      bus.abort = 1'b0;
      bus.start = 1'b0;
      cyc++;
    end
    if (cyc >= 4000) begin
      total++;
      bad++;
      $display("FAIL frame_timeout: got %0d cycles, required below 4000", cyc);
      expq.delete();
    end
    repeat (2) @(negedge clk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    int ones;
    logic [7:0] par_exp;
    rstn           = 1'b0;
    bus.start      = 1'b0;
    bus.tx_type    = 1'b0;
    bus.tx_len     = '0;
    bus.tx_data    = '0;
    bus.crc_append = 1'b0;
    bus.ui_cycle   = '0;
    bus.abort      = 1'b0;
    #3;
    check("reset_outputs", 32'({bus.data, bus.busy, bus.done, bus.err, bus.aborted}), 32'h0);
    #20;
    @(negedge clk); #1;
    rstn = 1'b1;

    // Ping only, U=20.
    run_frame(0, 1, 32'h0, 0, 20, -1, 0, 0);
    check("ping_len", trace.size(), 320);
    ones = 0;
    foreach (trace[i]) ones += int'(trace[i]);
    check("ping_ones", ones, 320);

    // Single byte A5 with an ignored start mid-frame.
    run_frame(1, 1, 32'hA5, 0, 20, -1, 1, 0);
    check("a5_len", trace.size(), 520);
    check("a5_sync", 32'({trace[2], trace[7], trace[12], trace[17]}), 32'hA);
    check("a5_byte", decode(20, 20), 8'hA5);
    check("a5_par", trace[190], 1);

    // CRC appended to 0x01.
    run_frame(1, 1, 32'h01, 1, 20, -1, 0, 0);
    check("crc_len", trace.size(), 720);
    check("crc_byte0", decode(20, 20), 8'h01);
    check("crc_byte1", decode(220, 20), 8'h07);
    check("crc_par", trace[390], 0);

    // Max frame, odd U.
    run_frame(1, 4, 32'h7F80FF00, 0, 22, -1, 0, 1);
    check("max_len", trace.size(), 1224);
    par_exp = 8'b0011;
    for (int b = 0; b < 4; b++) begin
      check("max_par", trace[b*218 + 20 + 176 + 11], par_exp[b]);
    end
    check("max_byte3", decode(3*218 + 20, 22), 8'h7F);

    // Rejects.
    run_frame(1, 1, 32'hA5, 0, 7, -1, 0, 0);
    check("rej_ui_busy", trace.size(), 0);
    run_frame(1, 0, 32'hA5, 0, 20, -1, 0, 0);
    check("rej_len0_busy", trace.size(), 0);
    run_frame(1, 5, 32'hA5, 0, 20, -1, 0, 0);
    check("rej_len5_busy", trace.size(), 0);

    // Abort at cycle 100, then a fresh frame.
    run_frame(1, 1, 32'hA5, 0, 20, 100, 0, 0);
    check("abort_busy_len", trace.size(), 100);
    run_frame(1, 1, 32'hA5, 0, 20, -1, 0, 0);
    check("after_abort_len", trace.size(), 520);
    check("after_abort_byte", decode(20, 20), 8'hA5);

    // Reset mid-frame.
    @(negedge clk); #1;
    bus.tx_type = 1'b1; bus.tx_len = 3'd2; bus.tx_data = 32'h1234;
    bus.crc_append = 1'b1; bus.ui_cycle = 8'd20; bus.start = 1'b1;
    model_launch(1, 2, 32'h1234, 1, 20);
    @(negedge clk); #1;
    bus.start = 1'b0;
    repeat (50) @(negedge clk);
    #1;
    rstn = 1'b0;
    #1;
    check("reset_mid", 32'({bus.data, bus.busy, bus.done, bus.err, bus.aborted}), 32'h0);
    expq.delete();
    @(negedge clk); #1;
    rstn = 1'b1;
    repeat (2) @(negedge clk);

    // Randomized frames.
    for (int n = 0; n < 25; n++) begin
      bit typ, ce, ms, sa;
      int len, u, ab;
      typ = ($urandom % 4) != 0;
      len = $urandom_range(0, 5);
      u   = $urandom_range(6, 24);
      ce  = 1'($urandom);
      ms  = 1'($urandom);
      sa  = ($urandom % 5) == 0;
      ab  = (($urandom % 4) == 0) ? $urandom_range(1, 600) : -1;
      run_frame(typ, len, $urandom, ce, u, ab, ms, sa);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
